test_pattern_gen: RTL and testbench

Parametrised video test-pattern source for the VGA pipeline; the successor to the fixed-gradient pattern framebuffer. It derives pixel and line coordinates from the `fb_hblank`/`fb_vblank` strobes and drives a registered RGB pixel stream, using synchronous edge detection only. It supports selectable patterns, configurable colour depth and a per-frame animation counter. It sits between the timing generator and the DAC/output formatter.

---
 rtl/test_pattern_gen_if.sv | 36 +++
 rtl/test_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_test_pattern_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/test_pattern_gen_if.sv
// Pixel-stream bundle between the VGA timing generator, the test-pattern
// source and the DAC/output formatter: blank strobes and pattern controls in,
// registered RGB + data enable + coordinates + frame bookkeeping out.
// master: pattern generator side; slave: timing/control driver and pixel sink.
interface test_pattern_gen_if #(
  parameter int COLOR_W = 8,
  parameter int X_W     = 11,
  parameter int Y_W     = 10
);
  // Timing strobes and pattern controls
  logic                   fb_hblank;
  logic                   fb_vblank;
  logic [2:0]             mode;
  logic                   freeze;
  logic [3*COLOR_W-1:0]   solid_rgb;

  // Registered pixel stream and frame bookkeeping
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   de;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [7:0]             frame_cnt;
  logic                   frame_start;

  modport master (
    input  fb_hblank, fb_vblank, mode, freeze, solid_rgb,
    output red, green, blue, de, x, y, frame_cnt, frame_start
  );

  modport slave (
    output fb_hblank, fb_vblank, mode, freeze, solid_rgb,
    input  red, green, blue, de, x, y, frame_cnt, frame_start
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Purpose: video test-pattern source; derives x/y from blank strobes, emits registered RGB.
// Latency: RGB/de one cycle after the cycle whose (x,y,active) they represent.
// Backpressure: none; one pixel per clock, the sink must always accept.
//
// Ports: vga_clk (pixel clock), reset_n (async active-low), pix (master modport):
//   in  fb_hblank/fb_vblank, mode, freeze, solid_rgb
//   out red/green/blue, de, x, y, frame_cnt, frame_start
// COLOR_W/X_W/Y_W must match the parameters of the connected interface instance.
module test_pattern_gen #(
  parameter int COLOR_W    = 8,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int BAR_LOG2   = 7,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  test_pattern_gen_if.master   pix
);

  localparam logic [X_W-1:0] X_MAX = {X_W{1'b1}};
  localparam logic [Y_W-1:0] Y_MAX = {Y_W{1'b1}};

  logic                 hb_q, vb_q;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [2:0]           mode_q, mode_d;
  logic                 frame_start_q, frame_start_d;
  logic                 de_q, de_d;
  logic [COLOR_W-1:0]   red_q, red_d;
  logic [COLOR_W-1:0]   green_q, green_d;
  logic [COLOR_W-1:0]   blue_q, blue_d;

  logic                 active, h_rise, v_rise, v_fall;
  logic [COLOR_W-1:0]   x_c, y_c, fc_c;
  logic [2:0]           bar_idx;
  logic                 chk_bit;
  logic [COLOR_W-1:0]   pat_r, pat_g, pat_b;

  always_comb begin
    active = ~pix.fb_hblank & ~pix.fb_vblank;
    h_rise = pix.fb_hblank & ~hb_q;
    v_rise = pix.fb_vblank & ~vb_q;
    v_fall = ~pix.fb_vblank & vb_q;
  end

  // Coordinate counters: cleared by blanking, saturating so an over-long line
  // or frame never aliases back onto pixel/line zero.
  always_comb begin
    x_d = x_q;
    if (pix.fb_hblank) begin
      x_d = '0;
    end else if (active && (x_q != X_MAX)) begin
      x_d = x_q + X_W'(1);
    end
  end

  // x_q != 0 at the hblank edge means the line just ended carried pixels, so
  // the vblank-to-first-line hblank stretch does not count as a line.
  // vblank takes priority, which also covers a coincident h_rise/v_rise.
  always_comb begin
    y_d = y_q;
    if (pix.fb_vblank) begin
      y_d = '0;
    end else if (h_rise && (x_q != '0) && (y_q != Y_MAX)) begin
      y_d = y_q + Y_W'(1);
    end
  end

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    mode_d        = mode_q;
    if (v_rise) begin
      mode_d = pix.mode;
      if (!pix.freeze) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
    frame_start_d = v_fall;
  end

  // Pattern operands are truncated/zero-extended to the channel width so all
  // arithmetic wraps modulo 2^COLOR_W.
  always_comb begin
    x_c     = COLOR_W'(x_q);
    y_c     = COLOR_W'(y_q);
    fc_c    = COLOR_W'(frame_cnt_q);
    bar_idx = 3'(x_q >> BAR_LOG2);
    chk_bit = x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2];
  end

  // Bar order white,yellow,cyan,green,magenta,red,blue,black reduces to each
  // channel being the inverse of one index bit: R=~i[1], G=~i[2], B=~i[0].
  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    unique case (mode_q)
      3'd0: begin
        pat_r = y_c;
        pat_g = x_c;
        pat_b = x_c + y_c;
      end
      3'd1: begin
        pat_r = {COLOR_W{~bar_idx[1]}};
        pat_g = {COLOR_W{~bar_idx[2]}};
        pat_b = {COLOR_W{~bar_idx[0]}};
      end
      3'd2: begin
        pat_r = {COLOR_W{chk_bit}};
        pat_g = {COLOR_W{chk_bit}};
        pat_b = {COLOR_W{chk_bit}};
      end
      3'd3: begin
        pat_r = pix.solid_rgb[3*COLOR_W-1 -: COLOR_W];
        pat_g = pix.solid_rgb[2*COLOR_W-1 -: COLOR_W];
        pat_b = pix.solid_rgb[COLOR_W-1   -: COLOR_W];
      end
      3'd4: begin
        pat_r = x_c + fc_c;
        pat_g = y_c;
        pat_b = fc_c;
      end
      default: begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
      end
    endcase
  end

  always_comb begin
    de_d    = active;
    red_d   = active ? pat_r : '0;
    green_d = active ? pat_g : '0;
    blue_d  = active ? pat_b : '0;
  end

  // Blank history resets to "blanking" so releasing reset inside a blank
  // interval produces no spurious edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_q          <= 1'b1;
      vb_q          <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      frame_cnt_q   <= '0;
      mode_q        <= '0;
      frame_start_q <= 1'b0;
      de_q          <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      hb_q          <= pix.fb_hblank;
      vb_q          <= pix.fb_vblank;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
      de_q          <= de_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign pix.red         = red_q;
  assign pix.green       = green_q;
  assign pix.blue        = blue_q;
  assign pix.de          = de_q;
  assign pix.x           = x_q;
  assign pix.y           = y_q;
  assign pix.frame_cnt   = frame_cnt_q;
  assign pix.frame_start = frame_start_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: two instances share one blank/control stream,
// A with wide counters, B with X_W=4/Y_W=3 so saturation is exercised.
// Expected pixels come from loop indices of the frame generator plus pattern rules.
module tb_test_pattern_gen;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hb = 1'b1;
  logic        vb = 1'b1;
  logic        freeze = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [23:0] solid = 24'h0;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_fc     = 0;
  int          m_mode   = 0;
  logic        prev_vb  = 1'b1;

  always #5 vga_clk = ~vga_clk;

  test_pattern_gen_if #(.COLOR_W(8), .X_W(11), .Y_W(10)) ifa ();
  test_pattern_gen_if #(.COLOR_W(8), .X_W(4),  .Y_W(3))  ifb ();

  assign ifa.fb_hblank = hb;
  assign ifa.fb_vblank = vb;
  assign ifa.mode      = mode;
  assign ifa.freeze    = freeze;
  assign ifa.solid_rgb = solid;
  assign ifb.fb_hblank = hb;
  assign ifb.fb_vblank = vb;
  assign ifb.mode      = mode;
  assign ifb.freeze    = freeze;
  assign ifb.solid_rgb = solid;

  test_pattern_gen #(.COLOR_W(8), .X_W(11), .Y_W(10), .BAR_LOG2(2), .CHECK_LOG2(2)) dut_a (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .pix     (ifa)
  );

  test_pattern_gen #(.COLOR_W(8), .X_W(4), .Y_W(3), .BAR_LOG2(2), .CHECK_LOG2(2)) dut_b (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .pix     (ifb)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [23:0] bar_color(input int i);
    case (i)
      0: return 24'hFFFFFF;  // white
      1: return 24'hFFFF00;  // yellow
      2: return 24'h00FFFF;  // cyan
      3: return 24'h00FF00;  // green
      4: return 24'hFF00FF;  // magenta
      5: return 24'hFF0000;  // red
      6: return 24'h0000FF;  // blue
      default: return 24'h000000;
    endcase
  endfunction

  // Colour for pixel (px,ln) as {r,g,b}, 8-bit channels, 4-px bars/squares.
  function automatic logic [23:0] pat(input int m, input int px, input int ln, input int fc);
    int r, g, b;
    r = 0; g = 0; b = 0;
    case (m)
      0: begin r = ln % 256; g = px % 256; b = (px + ln) % 256; end
      1: return bar_color((px / 4) % 8);
      2: begin
        if ((((px / 4) + (ln / 4)) % 2) == 1) return 24'hFFFFFF;
        return 24'h000000;
      end
      3: return solid;
      4: begin r = (px + fc) % 256; g = ln % 256; b = fc % 256; end
      default: return 24'h000000;
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive blanks, check coordinates mid-cycle, check registered outputs after the edge.
  task automatic step(input logic h, input logic v, input int px, input int ln);
    logic act, vr, vf;
    int xa, ya, xb, yb;
    logic [23:0] ea, eb;
    hb = h;
    vb = v;
    act = !h && !v;
    vr  = v && !prev_vb;
    vf  = !v && prev_vb;
    xa = imin(px, 2047); ya = imin(ln, 1023);
    xb = imin(px, 15);   yb = imin(ln, 7);
    @(negedge vga_clk);
    if (act) begin
      chk("x_a", 32'(ifa.x), xa);
      chk("y_a", 32'(ifa.y), ya);
      chk("x_b", 32'(ifb.x), xb);
      chk("y_b", 32'(ifb.y), yb);
    end
    ea = act ? pat(m_mode, xa, ya, m_fc) : 24'h0;
    eb = act ? pat(m_mode, xb, yb, m_fc) : 24'h0;
    @(posedge vga_clk);
    #1;
    if (vr) begin
      if (!freeze) m_fc = (m_fc + 1) % 256;
      m_mode = int'(mode);
    end
    chk("de_a",  32'(ifa.de), 32'(act));
    chk("rgb_a", 32'({ifa.red, ifa.green, ifa.blue}), 32'(ea));
    chk("de_b",  32'(ifb.de), 32'(act));
    chk("rgb_b", 32'({ifb.red, ifb.green, ifb.blue}), 32'(eb));
    chk("fs_a",  32'(ifa.frame_start), 32'(vf));
    chk("fs_b",  32'(ifb.frame_start), 32'(vf));
    chk("fc_a",  32'(ifa.frame_cnt), m_fc);
    chk("fc_b",  32'(ifb.frame_cnt), m_fc);
    prev_vb = v;
  endtask

  // Frame: vblank, then per line 4 hblank + w active; optional mode change at a line start.
  // simul=1 ends the last line straight into vblank (coincident h_rise/v_rise).
  task automatic frame(input int nl, input int w, input bit simul, input int sw_line, input int sw_mode);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 0, 0);
    for (int l = 0; l < nl; l++) begin
      if (l == sw_line) mode = 3'(sw_mode);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, l);
      for (int p = 0; p < w; p++) step(1'b0, 1'b0, p, l);
    end
    if (!simul) begin
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 0);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rgb_a", 32'({ifa.red, ifa.green, ifa.blue}), 0);
    chk("rst_rgb_b", 32'({ifb.red, ifb.green, ifb.blue}), 0);
    chk("rst_de_a",  32'(ifa.de), 0);
    chk("rst_xy_a",  32'({ifa.x, ifa.y}), 0);
    chk("rst_xy_b",  32'({ifb.x, ifb.y}), 0);
    chk("rst_fc_a",  32'(ifa.frame_cnt), 0);
    chk("rst_fs_a",  32'(ifa.frame_start), 0);
    chk("rst_fs_b",  32'(ifb.frame_start), 0);
  endtask

  initial begin
    int fc0;

    // Reset held with random blanking: every output stays zero.
    @(posedge vga_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      hb = 1'($urandom);
      vb = 1'($urandom);
      @(posedge vga_clk);
      #1;
      chk_reset_outputs();
    end

    // Release inside vblank: no frame_start until the first vblank fall.
    hb = 1'b1;
    vb = 1'b1;
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    prev_vb = 1'b1;
    m_fc = 0;
    m_mode = 0;

    // Gradient: 16 px x 4 lines.
    mode = 3'd0;
    frame(4, 16, 1'b0, -1, 0);
    frame(4, 16, 1'b0, -1, 0);

    // Bars across 32 px, ending in coincident h_rise/v_rise.
    mode = 3'd1;
    frame(4, 32, 1'b1, -1, 0);

    // Mode 0 -> 1 requested on line 2: stays gradient until the next frame.
    mode = 3'd0;
    frame(4, 16, 1'b0, 2, 1);
    frame(4, 16, 1'b0, -1, 0);

    // Checker, solid, scroll, black modes.
    mode = 3'd2;
    frame(8, 24, 1'b0, -1, 0);
    mode = 3'd3;
    solid = 24'($urandom);
    frame(2, 12, 1'b1, -1, 0);
    mode = 3'd4;
    frame(3, 20, 1'b0, -1, 0);
    for (int m = 5; m < 8; m++) begin
      mode = 3'(m);
      frame(2, 10, 1'b0, -1, 0);
    end

    // Freeze over 3 frames holds frame_cnt.
    mode = 3'd4;
    fc0 = m_fc;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) frame(2, 8, 1'b0, -1, 0);
    chk("freeze_hold", 32'(ifa.frame_cnt), fc0);
    freeze = 1'b0;

    // Saturation: 20-px lines on the 4-bit x instance, 10 lines on the 3-bit y instance.
    mode = 3'd0;
    frame(3, 20, 1'b0, -1, 0);
    frame(10, 6, 1'b1, -1, 0);

    // Random frames.
    for (int i = 0; i < 12; i++) begin
      mode   = 3'($urandom_range(0, 7));
      freeze = 1'($urandom_range(0, 3) == 0);
      solid  = 24'($urandom);
      frame($urandom_range(1, 6), $urandom_range(1, 40), 1'($urandom), $urandom_range(0, 6),
            $urandom_range(0, 7));
    end
    freeze = 1'b0;

    // 256 frames bring frame_cnt back to its starting value.
    mode = 3'd4;
    frame(1, 4, 1'b0, -1, 0);
    fc0 = m_fc;
    for (int i = 0; i < 256; i++) frame(1, 4, 1'($urandom), -1, 0);
    chk("fc_wrap", 32'(ifa.frame_cnt), fc0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
